// File: rtl/sha256_msg_sched_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched_if
// Stream bundle between the SHA-256 message-schedule generator and the
// hashing datapath around it.
//
// Handshake semantics (both streams): a word moves on a rising clock edge
// exactly when valid and ready are both high. The source holds valid and its
// payload stable until that edge. The sink may raise or drop ready at any
// time. Neither side may make valid depend combinationally on ready.
//
// Signals
//   in_valid / in_ready / in_word          message words into the scheduler
//   w_valid / w_ready / w_word /
//   k_word / round / w_last                per-round operands out of it
//
// Modports
//   slave  : the scheduler (sinks message words, sources W/K)
//   master : the surrounding datapath (sources message words, sinks W/K)
// ---------------------------------------------------------------------------
interface sha256_msg_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;

  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [31:0] k_word;
  logic [5:0]  round;
  logic        w_last;

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_word, k_word, round, w_last
  );

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_word, k_word, round, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// Sequential SHA-256 message-schedule generator. Loads one 512-bit block as
// sixteen 32-bit words (M_0 first), then emits W_0..W_63 one per handshake,
// each paired with its round constant K_t and round index t.
//
// Ports
//   ACLK       clock, all state changes on the rising edge
//   ARESETN    asynchronous active-low reset
//   clr        synchronous abort: drop the current block, back to LOAD
//   bus        sha256_msg_sched_if.slave: message-word input stream and
//              W/K/round output stream
//   busy       high while running or while a partial block is held
//   state_dbg  current FSM state (0 = LOAD, 1 = RUN)
//
// Every output is a plain decode of registers; nothing on the bus outputs
// depends combinationally on in_valid or w_ready.
// ---------------------------------------------------------------------------
module sha256_msg_sched (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              clr,
  sha256_msg_sched_if.slave bus,
  output logic              busy,
  output logic              state_dbg
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      state;
  logic [3:0]  lc;
  logic [5:0]  t;
  logic        in_ready_q;
  logic        w_valid_q;
  logic [31:0] win [16];

  logic        in_fire;
  logic        w_fire;
  logic        shift_en;
  logic [31:0] next_w;
  logic [31:0] fill;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign w_fire   = w_valid_q & bus.w_ready;
  // in_ready and w_valid are never high together, so at most one fire is live.
  // An abort cancels the shift so the window is left untouched.
  assign shift_en = ~clr & (in_fire | w_fire);

  // With win[0] = W_t, the window slots map to W_{t+1}, W_{t+9}, W_{t+14},
  // so this is the recurrence for W_{t+16}.
  assign next_w = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign fill   = w_valid_q ? next_w : bus.in_word;

  // Control FSM. in_ready and w_valid are registered copies of the next
  // state decode so they come straight off flops; in_ready is held low
  // during reset and comes up on the first edge after release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= S_LOAD;
      lc         <= '0;
      t          <= '0;
      in_ready_q <= 1'b0;
      w_valid_q  <= 1'b0;
    end else if (clr) begin
      state      <= S_LOAD;
      lc         <= '0;
      t          <= '0;
      in_ready_q <= 1'b1;
      w_valid_q  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            if (lc == 4'd15) begin
              lc         <= '0;
              t          <= '0;
              state      <= S_RUN;
              in_ready_q <= 1'b0;
              w_valid_q  <= 1'b1;
            end else begin
              lc <= lc + 4'd1;
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (t == 6'd63) begin
              t          <= '0;
              state      <= S_LOAD;
              in_ready_q <= 1'b1;
              w_valid_q  <= 1'b0;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        default: begin
          state      <= S_LOAD;
          in_ready_q <= 1'b1;
          w_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // 16-word sliding window. Loading and running share the same left shift;
  // only the word entering win[15] differs. Words generated after W_63 fall
  // into the window and are simply overwritten by the next load.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i + 1];
      end
      win[15] <= fill;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_word   = win[0];
  assign bus.k_word   = K_ROM[t];
  assign bus.round    = t;
  assign bus.w_last   = w_valid_q & (t == 6'd63);

  assign busy      = (state == S_RUN) | (lc != 4'd0);
  assign state_dbg = (state == S_RUN);

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic busy;
  logic state_dbg;

  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .clr       (clr),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_in_cyc;
  int last_w_cyc;

  // expected entry: {w, k, round, last}
  logic [70:0] exp_q[$];
  logic [31:0] blk_q[$];   // words of the block being loaded (model side)
  logic [31:0] src_q[$];   // words still to be offered by the driver

  logic [31:0] k_tab [64];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // K_t = first 32 fractional bits of the cube root of the t-th prime,
  // found by exact integer bisection on floor(cbrt(p * 2^96)).
  function automatic logic [31:0] cbrt_frac(input int unsigned p);
    logic [127:0] target, lo, hi, mid;
    target = 128'(p) << 96;
    lo = '0;
    hi = 128'(1) << 36;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid * mid <= target) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  task automatic build_k_tab();
    int n = 0;
    int unsigned p = 2;
    while (n < 64) begin
      bit is_prime = 1'b1;
      for (int unsigned d = 2; d * d <= p; d++) if (p % d == 0) is_prime = 1'b0;
      if (is_prime) begin
        k_tab[n] = cbrt_frac(p);
        n++;
      end
      p++;
    end
  endtask

  task automatic push_schedule();
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk_q[i];
    for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) exp_q.push_back({w[i], k_tab[i], 6'(i), (i == 63)});
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Inputs change and outputs are sampled at the falling edge; the handshake
  // resolved here is the one the DUT takes on the following rising edge.
  task automatic step(input logic iv, input logic [31:0] iw, input logic wr, input logic c,
                      output logic in_hs, output logic w_hs);
    @(negedge clk);
    cyc++;
    bus.in_valid = iv;
    bus.in_word  = iw;
    bus.w_ready  = wr;
    clr          = c;

    chk("in_ready",  80'(bus.in_ready), 80'(exp_q.size() == 0));
    chk("w_valid",   80'(bus.w_valid),  80'(exp_q.size() != 0));
    chk("busy",      80'(busy),         80'(exp_q.size() != 0 || blk_q.size() != 0));
    chk("state_dbg", 80'(state_dbg),    80'(exp_q.size() != 0));
    if (bus.w_valid && exp_q.size() != 0)
      chk("w_out", 80'({bus.w_word, bus.k_word, bus.round, bus.w_last}), 80'(exp_q[0]));

    in_hs = 1'b0;
    w_hs  = 1'b0;
    if (c) begin
      exp_q.delete();
      blk_q.delete();
    end else begin
      in_hs = iv & bus.in_ready;
      w_hs  = wr & bus.w_valid;
      if (w_hs && exp_q.size() != 0) begin
        cap_w[bus.round] = bus.w_word;
        cap_k[bus.round] = bus.k_word;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) last_w_cyc = cyc;
      end
      if (in_hs) begin
        if (first_in_cyc < 0) first_in_cyc = cyc;
        blk_q.push_back(iw);
        if (blk_q.size() == 16) begin
          push_schedule();
          blk_q.delete();
        end
      end
    end
  endtask

  // Offer src_q until everything is loaded and drained. stall is the
  // percentage of cycles in which in_valid / w_ready are dropped.
  task automatic stream(input int stall, input int clr_round, input int clr_words,
                        input int stop_round);
    int budget = 3000;
    int words_in = 0;
    bit clr_done = 1'b0;
    bit after_clr = 1'b0;
    logic iv, wr, c, in_hs, w_hs;
    logic [31:0] iw;
    first_in_cyc = -1;
    last_w_cyc = -1;
    while (!(src_q.size() == 0 && exp_q.size() == 0 && blk_q.size() == 0)) begin
      if (stop_round >= 0 && bus.w_valid && bus.round == 6'(stop_round)) break;
      if (budget == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL stream_timeout: got 3000 cycles without draining, required completion");
        break;
      end
      budget--;
      iv = (src_q.size() != 0) && ($urandom_range(99) >= stall);
      iw = iv ? src_q[0] : $urandom;
      wr = ($urandom_range(99) >= stall);
      c  = 1'b0;
      if (!clr_done && clr_round >= 0 && bus.w_valid && bus.round == 6'(clr_round)) begin
        c = 1'b1; wr = 1'b1; clr_done = 1'b1;
      end
      if (!clr_done && clr_words >= 0 && words_in == clr_words && src_q.size() != 0) begin
        c = 1'b1; iv = 1'b1; iw = src_q[0]; clr_done = 1'b1;
      end
      step(iv, iw, wr, c, in_hs, w_hs);
      if (in_hs) begin
        void'(src_q.pop_front());
        words_in++;
      end
      if (c) after_clr = 1'b1;
      else if (after_clr && w_hs) begin
        chk("abort_first_round", 80'(bus.round), 80'(0));
        after_clr = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Asynchronous reset away from any clock edge; release just after a
  // falling edge so the next sample is one rising edge later.
  task automatic do_reset();
    logic a, b;
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.w_ready  = 1'b0;
    clr = 1'b0;
    #1;
    chk("rst_w_valid",  80'(bus.w_valid),  80'(0));
    chk("rst_in_ready", 80'(bus.in_ready), 80'(0));
    chk("rst_round",    80'(bus.round),    80'(0));
    chk("rst_k_word",   80'(bus.k_word),   80'(32'h428a2f98));
    chk("rst_w_word",   80'(bus.w_word),   80'(0));
    chk("rst_w_last",   80'(bus.w_last),   80'(0));
    chk("rst_busy",     80'(busy),         80'(0));
    exp_q.delete();
    blk_q.delete();
    src_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, a, b);
    chk("release_in_ready", 80'(bus.in_ready), 80'(1));
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) src_q.push_back($urandom);
  endtask

  // ---------------- "abc" table ----------------
  typedef struct {
    int          rnd;
    logic [31:0] w;
    logic [31:0] k;
    bit          has_w;
  } abc_vec_t;

  abc_vec_t tbl [9];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.w_ready  = 1'b0;

    tbl[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b1};
    tbl[1] = '{1,  32'h00000000, 32'h71374491, 1'b1};
    tbl[2] = '{14, 32'h00000000, 32'h9bdc06a7, 1'b1};
    tbl[3] = '{15, 32'h00000018, 32'hc19bf174, 1'b1};
    tbl[4] = '{16, 32'h61626380, 32'he49b69c1, 1'b1};
    tbl[5] = '{17, 32'h000f0000, 32'hefbe4786, 1'b1};
    tbl[6] = '{18, 32'h7da86405, 32'h0fc19dc6, 1'b1};
    tbl[7] = '{32, 32'h00000000, 32'h27b70a85, 1'b0};
    tbl[8] = '{63, 32'h00000000, 32'hc67178f2, 1'b0};

    build_k_tab();

    // power-on reset
    do_reset();

    // "abc" block, no stalls: 80-cycle block period and table vectors
    for (int i = 0; i < 64; i++) begin cap_w[i] = '0; cap_k[i] = '0; end
    src_q.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) src_q.push_back(32'h0);
    src_q.push_back(32'h00000018);
    stream(0, -1, -1, -1);
    chk("abc_period", 80'(last_w_cyc - first_in_cyc + 1), 80'(80));
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("abc_k%0d", tbl[i].rnd), 80'(cap_k[tbl[i].rnd]), 80'(tbl[i].k));
      if (tbl[i].has_w)
        chk($sformatf("abc_w%0d", tbl[i].rnd), 80'(cap_w[tbl[i].rnd]), 80'(tbl[i].w));
    end

    // backpressure on both streams
    random_block();
    stream(40, -1, -1, -1);
    random_block();
    stream(70, -1, -1, -1);

    // abort at round 20, then a new block
    random_block();
    random_block();
    stream(0, 20, -1, -1);

    // abort after 7 loaded words; the next 16 form a fresh block
    for (int i = 0; i < 23; i++) src_q.push_back($urandom);
    stream(30, -1, 7, -1);

    // back-to-back blocks, continuous valid/ready
    random_block();
    random_block();
    stream(0, -1, -1, -1);
    chk("b2b_period", 80'(last_w_cyc - first_in_cyc + 1), 80'(160));

    // reset in the middle of RUN, then a normal block
    random_block();
    stream(0, -1, -1, 30);
    chk("pre_reset_round", 80'(bus.round), 80'(30));
    do_reset();
    random_block();
    stream(20, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got 900000 time units, required earlier finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Sequential SHA-256 message-schedule generator: the producer feeding the W/K operands of the combinational per-round compression step. It accepts one 512-bit block as sixteen 32-bit words over a valid/ready stream, then emits W_0..W_63, each paired with its round constant K_t and round index, over a second valid/ready stream. It sits between block buffering and the round iterator/pipeline in the hashing datapath.

## Interface
- Parameters: none. Block size of 16 words and round count of 64 are fixed.
- ACLK  in  1  sole clock; all state updates on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort: drop the current block and return to load state
- in_valid  in  1  in_word valid
- in_ready  out  1  block accepts a message word
- in_word  in  32  message word, M_0 first, big-endian word packing already applied upstream
- w_valid  out  1  w_word/k_word/round valid
- w_ready  in  1  downstream round logic consumes the current W
- w_word  out  32  W_t
- k_word  out  32  K_t, the standard SHA-256 constant for round t (K_0=0x428a2f98 … K_63=0xc67178f2)
- round  out  6  t
- w_last  out  1  high with w_valid when t=63
- busy  out  1  high when not in LOAD or when at least one word is loaded

## Operation
- FSM states:
  - LOAD: in_ready=1, w_valid=0.
  - RUN: in_ready=0, w_valid=1.
- Window: 16×32 register window win[0..15], with win[0]=W_t.
- LOAD:
  - Each in handshake shifts win left (win[i]←win[i+1]), writes in_word to win[15] and increments load count lc (0..15).
  - The handshake with lc=15 sets lc←0, t←0 and goes to RUN. win[0..15] then hold M_0..M_15.
- RUN:
  - w_word=win[0], k_word=K[t] from a 64-entry constant ROM, round=t.
  - Each w handshake shifts win left and writes win[15]←σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32. This yields W_{t+16}.
  - Each w handshake also increments t.
  - The handshake at t=63 goes to LOAD with t←0. Words computed past W_63 are discarded.
- Sigma functions (ROTR = rotate right, SHR = logical shift right):
  - σ0(x)=ROTR7(x)^ROTR18(x)^SHR3(x)
  - σ1(x)=ROTR17(x)^ROTR19(x)^SHR10(x)
- No handshake (w_valid & !w_ready, or in_valid low): all state and outputs hold.
- clr=1:
  - Next state is LOAD, lc←0, t←0.
  - clr overrides any same-cycle in or w handshake, which is ignored and not counted.
  - The window content is left as is; it is fully overwritten by the next load.
- Reset values (ARESETN low, asynchronous):
  - State LOAD, lc=0, t=0, win all 0.
  - Outputs: in_ready=0 while ARESETN=0, then 1 from the first cycle after release; w_valid=0; w_word=0; k_word=0x428a2f98; round=0; w_last=0; busy=0.

## Timing
- Outputs decode from registers only. There is no combinational path from in_valid or w_ready to any output.
- w_valid rises in the cycle after the 16th in handshake.
- In RUN, w_word, k_word, round and w_last are stable while w_valid=1 and w_ready=0. They change only in the cycle after a handshake.
- Throughput is one W per cycle with w_ready held high.
- Minimum block period is 80 cycles: 16 load + 64 run.
- in_ready rises in the cycle after the t=63 handshake. There are no dead cycles between blocks.
- Streams never overlap: in_ready and w_valid are never high together.

## Test plan
- Reset:
  - Stimulus: assert ARESETN=0 mid-RUN, then release.
  - Required response: w_valid=0, round=0, k_word=0x428a2f98, in_ready=1 one cycle after release, busy=0.
- "abc" block:
  - Stimulus: M_0=0x61626380, M_1..M_14=0, M_15=0x00000018, with w_ready=1.
  - Required response: W_0..W_15 equal the inputs; W_16=0x61626380; W_17=0x000f0000; W_18=0x7da86405.
  - All 64 W and K match the software model; w_last only at round=63; 80-cycle block.
- Backpressure:
  - Stimulus: random w_ready and in_valid stalls.
  - Required response: outputs hold during stalls, no skipped or duplicated round, same 64 words as the stall-free run.
- Abort:
  - Stimulus: clr at round=20 together with w_ready=1, then load a new block.
  - Required response: the next w_valid is for round=0 of the new block; no W from the old block appears.
- Partial-load abort:
  - Stimulus: clr after 7 words.
  - Required response: the next 16 words form a fresh block, checked against the model.
- Back-to-back:
  - Stimulus: two random blocks with continuous valid/ready.
  - Required response: in_ready=1 in the cycle after w_last handshake; 160 cycles total; both schedules match the model.
